// File: rtl/tap_mux_if.sv
// tap_mux_if: lane bus, controls and results of tap_mux_seq.
// The hold signal exists only when TAP_MUX_HOLD_EN is defined.
interface tap_mux_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic                    start;
`ifdef TAP_MUX_HOLD_EN
    logic                    hold;
`endif
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_idx;
    logic                    out_last;
    logic                    busy;
`ifdef TAP_MUX_HOLD_EN
    modport master (output in_bus, mode, select, start, hold,
                    input  out, out_valid, out_idx, out_last, busy);
    modport slave  (input  in_bus, mode, select, start, hold,
                    output out, out_valid, out_idx, out_last, busy);
`else
    modport master (output in_bus, mode, select, start,
                    input  out, out_valid, out_idx, out_last, busy);
    modport slave  (input  in_bus, mode, select, start,
                    output out, out_valid, out_idx, out_last, busy);
`endif
endinterface

// File: rtl/tap_mux_seq.sv
// tap_mux_seq: N:1 registered tap mux with direct select or a lane-walking sequence mode.
// Optional sequencer freeze via TAP_MUX_HOLD_EN.
module tap_mux_seq #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input logic      clk,
    input logic      rst,
    tap_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d, last_q, last_d;
    logic [SEL_W-1:0] idx_q, idx_d, nxt_idx;
    logic             hold_w;
    logic [WIDTH-1:0] lanes [2**SEL_W];

    // Pad to a power of two so any select value indexes a real entry.
    genvar g;
    for (g = 0; g < 2**SEL_W; g++) begin : g_lane
        if (g < NUM_IN) begin : g_in
            assign lanes[g] = bus.in_bus[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign lanes[g] = '0;
        end
    end

`ifdef TAP_MUX_HOLD_EN
    assign hold_w = bus.hold;
`else
    assign hold_w = 1'b0;
`endif

    assign nxt_idx = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (state_q == IDLE) begin
            if (!bus.mode) begin
                idx_d   = bus.select;
                valid_d = 32'(bus.select) < NUM_IN;
                out_d   = valid_d ? lanes[bus.select] : '0;
            end else if (bus.start) begin
                state_d = RUN;
                idx_d   = '0;
                out_d   = lanes[0];
                valid_d = 1'b1;
            end
        end else if (hold_w) begin
            last_d = last_q;
        end else if (idx_q != LAST_IDX) begin
            idx_d   = nxt_idx;
            out_d   = lanes[nxt_idx];
            valid_d = 1'b1;
            last_d  = nxt_idx == LAST_IDX;
        end else if (bus.start && bus.mode) begin
            // Chained restart: lane 0 follows the last beat with no bubble.
            idx_d   = '0;
            out_d   = lanes[0];
            valid_d = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = state_q == RUN;
endmodule

// File: tb/tb_tap_mux_seq.sv
// tb_tap_mux_seq: directed checks of tap_mux_seq at 8x4 and 16x5.
// Hold scenario runs only when TAP_MUX_HOLD_EN is defined.
module tb_tap_mux_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tap_mux_if #(.WIDTH(8),  .NUM_IN(4)) a_if ();
    tap_mux_if #(.WIDTH(16), .NUM_IN(5)) b_if ();

    tap_mux_seq #(.WIDTH(8),  .NUM_IN(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    tap_mux_seq #(.WIDTH(16), .NUM_IN(5)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int n_cmp = 0;
    int n_fail = 0;
    int lane_a [4] = '{19, 63, 1, 0};

    // {out, out_valid, out_idx, out_last, busy}
    wire [12:0] got_a = {a_if.out, a_if.out_valid, a_if.out_idx, a_if.out_last, a_if.busy};
    wire [21:0] got_b = {b_if.out, b_if.out_valid, b_if.out_idx, b_if.out_last, b_if.busy};
    localparam logic [12:0] CTRL_A = 13'h013;
    localparam logic [21:0] CTRL_B = 22'h000023;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [12:0] ea;
        logic [21:0] eb;
        ea = '0;
        eb = '0;
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if (got_a !== ea) begin n_fail++; $display("FAIL reset_a: got %h want %h", got_a, ea); end
        n_cmp++;
        if (got_b !== eb) begin n_fail++; $display("FAIL reset_b: got %h want %h", got_b, eb); end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_direct;
        int sel [5] = '{0, 0, 1, 1, 3};
        logic [12:0] e;
        for (int i = 0; i < 5; i++) begin
            a_if.select = 2'(sel[i]);
            step();
            e = {8'(lane_a[sel[i]]), 1'b1, 2'(sel[i]), 1'b0, 1'b0};
            n_cmp++;
            if (got_a !== e) begin n_fail++; $display("FAIL direct step %0d: got %h want %h", i, got_a, e); end
        end
    endtask

    task automatic test_sequence;
        logic [12:0] e;
        a_if.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_if.start = (i == 0);
            step();
            e = (i < 4) ? {8'(lane_a[i]), 1'b1, 2'(i), i == 3, 1'b1} : 13'h0;
            n_cmp++;
            if ((got_a & ((i < 4) ? 13'h1fff : CTRL_A)) !== e)
                begin n_fail++; $display("FAIL sequence beat %0d: got %h want %h", i, got_a, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] e;
        for (int i = 0; i < 9; i++) begin
            a_if.start = (i == 0 || i == 4);
            step();
            e = (i < 8) ? {8'(lane_a[i%4]), 1'b1, 2'(i%4), (i%4) == 3, 1'b1} : 13'h0;
            n_cmp++;
            if ((got_a & ((i < 8) ? 13'h1fff : CTRL_A)) !== e)
                begin n_fail++; $display("FAIL chained beat %0d: got %h want %h", i, got_a, e); end
        end
        a_if.start = 1'b0;
    endtask

    task automatic test_disturb;
        logic [12:0] e;
        for (int i = 0; i < 5; i++) begin
            a_if.start = (i == 0);
            step();
            e = (i < 4) ? {8'(lane_a[i]), 1'b1, 2'(i), i == 3, 1'b1} : 13'h0;
            n_cmp++;
            if ((got_a & ((i < 4) ? 13'h1fff : CTRL_A)) !== e)
                begin n_fail++; $display("FAIL disturb beat %0d: got %h want %h", i, got_a, e); end
            if (i == 1) begin a_if.mode = 1'b0; a_if.select = 2'd2; end
        end
        a_if.mode = 1'b1;
        a_if.select = 2'd0;
        for (int i = 0; i < 3; i++) begin
            a_if.start = (i == 0);
            step();
            e = {8'(lane_a[i]), 1'b1, 2'(i), 1'b0, 1'b1};
            n_cmp++;
            if (got_a !== e) begin n_fail++; $display("FAIL rerun beat %0d: got %h want %h", i, got_a, e); end
        end
        a_if.start = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (got_a !== 13'h0) begin n_fail++; $display("FAIL midrun_reset: got %h want %h", got_a, 13'h0); end
        rst = 1'b0;
        step();
        n_cmp++;
        if (got_a !== 13'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", got_a, 13'h0); end
    endtask

    task automatic test_param;
        logic [21:0] e;
        b_if.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_if.start = (i == 0);
            step();
            e = (i < 5) ? {16'(1000 + i), 1'b1, 3'(i), i == 4, 1'b1} : 22'h0;
            n_cmp++;
            if ((got_b & ((i < 5) ? 22'h3fffff : CTRL_B)) !== e)
                begin n_fail++; $display("FAIL param beat %0d: got %h want %h", i, got_b, e); end
        end
        b_if.mode = 1'b0;
        b_if.select = 3'd4;
        step();
        e = {16'd1004, 1'b1, 3'd4, 1'b0, 1'b0};
        n_cmp++;
        if (got_b !== e) begin n_fail++; $display("FAIL param_sel4: got %h want %h", got_b, e); end
        b_if.select = 3'd6;
        step();
        e = {16'd0, 1'b0, 3'd6, 1'b0, 1'b0};
        n_cmp++;
        if (got_b !== e) begin n_fail++; $display("FAIL param_sel6: got %h want %h", got_b, e); end
        b_if.select = 3'd0;
    endtask

`ifdef TAP_MUX_HOLD_EN
    task automatic test_hold;
        int ev [7] = '{19, 63, 63, 63, 1, 0, 0};
        int ei [7] = '{0, 1, 1, 1, 2, 3, 0};
        logic [12:0] e;
        a_if.mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_if.start = (i == 0);
            a_if.hold = (i == 2 || i == 3);
            step();
            e = (i < 6) ? {8'(ev[i]), !(i == 2 || i == 3), 2'(ei[i]), i == 5, 1'b1} : 13'h0;
            n_cmp++;
            if ((got_a & ((i < 6) ? 13'h1fff : CTRL_A)) !== e)
                begin n_fail++; $display("FAIL hold beat %0d: got %h want %h", i, got_a, e); end
        end
        a_if.hold = 1'b0;
    endtask
`endif

    initial begin
        a_if.in_bus = {8'd0, 8'd1, 8'd63, 8'd19};
        a_if.mode = 1'b0;
        a_if.select = '0;
        a_if.start = 1'b0;
        b_if.in_bus = {16'd1004, 16'd1003, 16'd1002, 16'd1001, 16'd1000};
        b_if.mode = 1'b0;
        b_if.select = '0;
        b_if.start = 1'b0;
`ifdef TAP_MUX_HOLD_EN
        a_if.hold = 1'b0;
        b_if.hold = 1'b0;
`endif
        test_reset();
        test_direct();
        test_sequence();
        test_back_to_back();
        test_disturb();
        test_param();
`ifdef TAP_MUX_HOLD_EN
        test_hold();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
